// File: rtl/topk_pkg.sv
// topk_pkg: shared FSM state encoding and output-beat record for the top-k query reader
package topk_pkg;
  localparam int BEAT_ADDR_W = 64;
  localparam int BEAT_CNT_W  = 64;
  localparam int BEAT_RANK_W = 16;
  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SETTLE,
    ST_READ,
    ST_DRAIN,
    ST_DONE
  } state_t;
  // Fields are sized for the widest supported configuration; the reader zero-extends into them.
  typedef struct packed {
    logic [BEAT_ADDR_W-1:0] addr;
    logic [BEAT_CNT_W-1:0]  cnt;
    logic [BEAT_RANK_W-1:0] rank;
  } beat_t;
endpackage

// File: rtl/topk_out_fifo.sv
// topk_out_fifo: 2-entry beat buffer between CAM read returns and the out_* stream
// Ports: i_push/i_din write, i_pop consumes o_dout (head), o_full/o_empty/o_count status.
module topk_out_fifo
  import topk_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       i_push,
  input  beat_t      i_din,
  input  logic       i_pop,
  output beat_t      o_dout,
  output logic       o_full,
  output logic       o_empty,
  output logic [1:0] o_count
);
  beat_t      r_mem [2];
  logic       r_wp, r_rp;
  logic [1:0] r_cnt;
  logic       w_push, w_pop;
  assign w_push  = i_push & ~o_full;
  assign w_pop   = i_pop & ~o_empty;
  assign o_full  = r_cnt == 2'd2;
  assign o_empty = r_cnt == 2'd0;
  assign o_count = r_cnt;
  assign o_dout  = r_mem[r_rp];
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_mem <= '{default: '0};
      r_wp  <= 1'b0;
      r_rp  <= 1'b0;
      r_cnt <= 2'd0;
    end else begin
      if (w_push) r_mem[r_wp] <= i_din;
      if (w_push) r_wp <= ~r_wp;
      if (w_pop) r_rp <= ~r_rp;
      r_cnt <= r_cnt + {1'b0, w_push} - {1'b0, w_pop};
    end
  end
endmodule

// File: rtl/topk_query_reader.sv
// topk_query_reader: freezes a sorted CAM and streams its top-k (addr, cnt) entries as ranked beats
// Ports: query_* accepts k and a clear request; cam_* freezes and reads the CAM (1-cycle read
// latency); out_* streams beats with valid/ready; done_* pulses the beat count; clear_pulse
// requests a sketch/CAM clear after readout.
module topk_query_reader
  import topk_pkg::*;
#(
  parameter int ADDR_SIZE  = 22,
  parameter int CNT_SIZE   = 32,
  parameter int NUM_ENTRY  = 25,
  parameter int INDEX_SIZE = 5,
  parameter int SETTLE_CYC = 2
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  query_valid,
  output logic                  query_ready,
  input  logic [INDEX_SIZE:0]   query_k,
  input  logic                  query_clear,
  output logic                  cam_freeze,
  output logic                  cam_rd_en,
  output logic [INDEX_SIZE-1:0] cam_rd_idx,
  input  logic                  cam_rd_valid,
  input  logic [ADDR_SIZE-1:0]  cam_rd_addr,
  input  logic [CNT_SIZE-1:0]   cam_rd_cnt,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [ADDR_SIZE-1:0]  out_addr,
  output logic [CNT_SIZE-1:0]   out_cnt,
  output logic [INDEX_SIZE-1:0] out_rank,
  output logic                  done_valid,
  output logic [INDEX_SIZE:0]   done_num,
  output logic                  clear_pulse
);
  localparam int SW = SETTLE_CYC > 1 ? $clog2(SETTLE_CYC) : 1;
  localparam logic [INDEX_SIZE:0] K_MAX = (INDEX_SIZE+1)'(NUM_ENTRY);
  state_t                r_state, w_next;
  logic [INDEX_SIZE:0]   r_k, r_issued, r_beats, w_k;
  logic [INDEX_SIZE-1:0] r_pend_idx;
  logic [SW-1:0]         r_settle;
  logic                  r_clear, r_pending, r_eol;
  logic                  w_accept, w_ret, w_eol_now, w_push, w_pop, w_full, w_empty;
  logic [1:0]            w_cnt;
  logic [2:0]            w_load;
  beat_t                 w_din, w_head;
  logic                  w_unused_bits;
  assign w_k       = query_k > K_MAX ? K_MAX : query_k;
  assign w_accept  = query_valid & query_ready;
  assign w_ret     = cam_rd_valid & r_pending;
  assign w_eol_now = w_ret & (cam_rd_cnt == '0);
  assign w_push    = w_ret & ~w_eol_now;
  assign w_pop     = out_valid & out_ready;
  // A beat leaving this cycle frees its slot now, which sustains one read per cycle.
  assign w_load    = 3'(w_cnt) + 3'(r_pending) - 3'(w_pop);
  assign cam_rd_en = (r_state == ST_READ) & ~r_eol & ~w_eol_now & (r_issued < r_k) & (w_load < 3'd2);
  assign cam_rd_idx = r_issued[INDEX_SIZE-1:0];
  assign w_din = '{addr: BEAT_ADDR_W'(cam_rd_addr), cnt: BEAT_CNT_W'(cam_rd_cnt), rank: BEAT_RANK_W'(r_pend_idx)};
  topk_out_fifo u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_push  (w_push),
    .i_din   (w_din),
    .i_pop   (w_pop),
    .o_dout  (w_head),
    .o_full  (w_full),
    .o_empty (w_empty),
    .o_count (w_cnt)
  );
  assign w_unused_bits = ^{w_head, w_full};
  assign out_valid   = ~w_empty;
  assign out_addr    = w_head.addr[ADDR_SIZE-1:0];
  assign out_cnt     = w_head.cnt[CNT_SIZE-1:0];
  assign out_rank    = w_head.rank[INDEX_SIZE-1:0];
  assign query_ready = r_state == ST_IDLE;
  assign done_valid  = r_state == ST_DONE;
  assign done_num    = r_beats;
  assign clear_pulse = done_valid & r_clear;
  // A k==0 query passes through DONE without ever freezing the CAM.
  assign cam_freeze  = (r_state inside {ST_SETTLE, ST_READ, ST_DRAIN}) | (done_valid & (r_k != '0));
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= ST_IDLE;
    else r_state <= w_next;
  end
  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_IDLE:   if (w_accept) w_next = w_k == '0 ? ST_DONE : SETTLE_CYC == 0 ? ST_READ : ST_SETTLE;
      ST_SETTLE: if (r_settle == SW'(SETTLE_CYC - 1)) w_next = ST_READ;
      ST_READ:   if (r_issued == r_k || r_eol || w_eol_now) w_next = ST_DRAIN;
      ST_DRAIN:  if (!r_pending && w_empty) w_next = ST_DONE;
      ST_DONE:   w_next = ST_IDLE;
      default:   w_next = ST_IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_k        <= '0;
      r_clear    <= 1'b0;
      r_issued   <= '0;
      r_beats    <= '0;
      r_eol      <= 1'b0;
      r_settle   <= '0;
      r_pending  <= 1'b0;
      r_pend_idx <= '0;
    end else begin
      if (w_accept) begin
        r_k      <= w_k;
        r_clear  <= query_clear;
        r_issued <= '0;
        r_beats  <= '0;
        r_eol    <= 1'b0;
        r_settle <= '0;
      end
      if (r_state == ST_SETTLE) r_settle <= r_settle + SW'(1);
      if (cam_rd_en) begin
        r_issued   <= r_issued + 1'b1;
        r_pend_idx <= r_issued[INDEX_SIZE-1:0];
      end
      // Read data always returns exactly one cycle after the request.
      r_pending <= cam_rd_en;
      if (w_eol_now) r_eol <= 1'b1;
      if (w_pop) r_beats <= r_beats + 1'b1;
    end
  end
endmodule

// File: tb/tb_topk_query_reader.sv
// tb_topk_query_reader: randomized scoreboard bench for topk_query_reader against a CAM reference model
module tb_topk_query_reader;
  localparam int AW = 22, CW = 32, NE = 25, IW = 5, SC = 2;
  logic          clk = 1'b0, rst_n = 1'b0;
  logic          query_valid = 1'b0, query_clear = 1'b0, out_ready = 1'b0;
  logic [IW:0]   query_k = '0;
  logic          query_ready, cam_freeze, cam_rd_en, out_valid, done_valid, clear_pulse;
  logic [IW-1:0] cam_rd_idx, out_rank;
  logic          cam_rd_valid = 1'b0;
  logic [AW-1:0] cam_rd_addr = '0, out_addr;
  logic [CW-1:0] cam_rd_cnt = '0, out_cnt;
  logic [IW:0]   done_num;
  always #5 clk = ~clk;
  topk_query_reader #(.ADDR_SIZE(AW), .CNT_SIZE(CW), .NUM_ENTRY(NE), .INDEX_SIZE(IW), .SETTLE_CYC(SC)) dut (
    .clk(clk), .rst_n(rst_n), .query_valid(query_valid), .query_ready(query_ready), .query_k(query_k),
    .query_clear(query_clear), .cam_freeze(cam_freeze), .cam_rd_en(cam_rd_en), .cam_rd_idx(cam_rd_idx),
    .cam_rd_valid(cam_rd_valid), .cam_rd_addr(cam_rd_addr), .cam_rd_cnt(cam_rd_cnt), .out_valid(out_valid),
    .out_ready(out_ready), .out_addr(out_addr), .out_cnt(out_cnt), .out_rank(out_rank),
    .done_valid(done_valid), .done_num(done_num), .clear_pulse(clear_pulse)
  );
  typedef struct {logic [AW-1:0] addr; logic [CW-1:0] cnt; int rank;} beat_s;
  typedef struct {int num; bit clr; bit frz;} done_s;
  beat_s         exp_beats[$];
  done_s         exp_done[$];
  int            beat_cyc[$];
  logic [AW-1:0] cam_addr_m[NE];
  logic [CW-1:0] cam_cnt_m[NE];
  int            n_checks = 0, n_fail = 0, cyc = 0, done_seen = 0;
  int            rd_next = 0, k_eff_cur = 0, freeze_cnt = 0, pushed = 0, popped = 0, mode = 0, beats_this = 0;
  bit            prev_rd = 0, prev_stall = 0, rsp_en = 0;
  int            rsp_idx = 0;
  logic [AW-1:0] s_addr;
  logic [CW-1:0] s_cnt;
  logic [IW-1:0] s_rank;
  beat_s         mon_b;
  done_s         mon_d;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // CAM read port model: data for the index requested in one cycle appears in the next.
  initial forever begin
    @(negedge clk);
    rsp_en  = cam_rd_en;
    rsp_idx = int'(cam_rd_idx);
    @(posedge clk);
    #1;
    cam_rd_valid = rsp_en;
    cam_rd_addr  = (rsp_en && rsp_idx < NE) ? cam_addr_m[rsp_idx] : '0;
    cam_rd_cnt   = (rsp_en && rsp_idx < NE) ? cam_cnt_m[rsp_idx] : '0;
  end

  initial forever begin
    @(posedge clk);
    #1;
    out_ready = mode == 0 ? 1'b1 : mode == 1 ? ~out_ready : 1'($urandom_range(0, 1));
  end

  always @(negedge clk) if (rst_n) begin
    cyc++;
    chk("load_le_2", 64'((pushed - popped + int'(prev_rd)) <= 2), 1);
    chk("out_valid_vs_model", out_valid, 64'((pushed - popped) > 0));
    if (prev_stall) begin
      chk("stall_valid", out_valid, 1);
      chk("stall_addr", out_addr, s_addr);
      chk("stall_cnt", out_cnt, s_cnt);
      chk("stall_rank", out_rank, s_rank);
    end
    if (out_valid && out_ready) begin
      chk("beat_expected", 64'(exp_beats.size() != 0), 1);
      if (exp_beats.size() != 0) begin
        mon_b = exp_beats.pop_front();
        chk("beat_addr", out_addr, mon_b.addr);
        chk("beat_cnt", out_cnt, mon_b.cnt);
        chk("beat_rank", out_rank, 64'(mon_b.rank));
      end
      beats_this++;
      beat_cyc.push_back(cyc);
      popped++;
    end
    if (cam_rd_en) begin
      chk("rd_idx", cam_rd_idx, 64'(rd_next));
      chk("rd_within_k", 64'(rd_next < k_eff_cur), 1);
      chk("rd_freeze", cam_freeze, 1);
      rd_next++;
    end
    if (cam_freeze) freeze_cnt++;
    if (cam_rd_valid && cam_rd_cnt != '0) pushed++;
    if (done_valid) begin
      chk("done_expected", 64'(exp_done.size() != 0), 1);
      if (exp_done.size() != 0) begin
        mon_d = exp_done.pop_front();
        chk("done_num", done_num, 64'(mon_d.num));
        chk("clear_pulse", clear_pulse, 64'(mon_d.clr));
        chk("done_freeze", cam_freeze, 64'(mon_d.frz));
      end
      done_seen++;
    end else if (clear_pulse) chk("clear_outside_done", clear_pulse, 0);
    prev_rd    = cam_rd_en;
    prev_stall = out_valid && !out_ready;
    s_addr = out_addr;
    s_cnt  = out_cnt;
    s_rank = out_rank;
  end

  // Sorted CAM contents: first nz entries nonzero and nonincreasing, the rest empty.
  task automatic fill_cam(input int nz);
    int c = 2000 + int'($urandom_range(0, 500));
    for (int i = 0; i < NE; i++) begin
      cam_addr_m[i] = AW'($urandom);
      cam_cnt_m[i]  = i < nz ? CW'(c) : '0;
      c -= int'($urandom_range(0, 50));
    end
  endtask

  task automatic run_query(input int k, input bit clr, input int md);
    int ke = k > NE ? NE : k, nb = 0, p = -1, d0;
    mode = md;
    for (int i = 0; i < ke; i++) begin
      if (cam_cnt_m[i] == '0) begin
        p = i;
        break;
      end
      exp_beats.push_back('{cam_addr_m[i], cam_cnt_m[i], i});
      nb++;
    end
    exp_done.push_back('{nb, clr, ke != 0});
    for (int i = 0; i < 100 && !query_ready; i++) @(negedge clk);
    chk("idle_before_query", query_ready, 1);
    rd_next = 0;
    freeze_cnt = 0;
    beats_this = 0;
    beat_cyc.delete();
    k_eff_cur = ke;
    d0 = done_seen;
    @(posedge clk);
    #1;
    query_valid = 1'b1;
    query_k = (IW+1)'(k);
    query_clear = clr;
    @(posedge clk);
    #1;
    query_valid = 1'b0;
    if (ke == 0) begin
      @(negedge clk);
      chk("k0_done_next_cycle", done_valid, 1);
    end
    for (int i = 0; i < 3000 && done_seen == d0; i++) @(negedge clk);
    chk("done_within_bound", 64'(done_seen != d0), 1);
    chk("beats_in_query", 64'(beats_this), 64'(nb));
    if (ke == 0) chk("k0_no_freeze", 64'(freeze_cnt), 0);
    if (p < 0) chk("reads_exact", 64'(rd_next), 64'(ke));
    else begin
      chk("reads_min", 64'(rd_next >= p + 1), 1);
      chk("reads_max", 64'(rd_next <= ((p + 2) < ke ? p + 2 : ke)), 1);
    end
    if (md == 0)
      for (int i = 1; i < beat_cyc.size(); i++) chk("beat_back_to_back", 64'(beat_cyc[i] - beat_cyc[i-1]), 1);
  endtask

  task automatic reset_mid_query();
    int d0;
    fill_cam(NE);
    mode = 0;
    for (int i = 0; i < 4; i++) exp_beats.push_back('{cam_addr_m[i], cam_cnt_m[i], i});
    exp_done.push_back('{4, 1'b1, 1'b1});
    for (int i = 0; i < 100 && !query_ready; i++) @(negedge clk);
    rd_next = 0;
    beats_this = 0;
    k_eff_cur = 4;
    @(posedge clk);
    #1;
    query_valid = 1'b1;
    query_k = 4;
    query_clear = 1'b1;
    @(posedge clk);
    #1;
    query_valid = 1'b0;
    for (int i = 0; i < 200 && beats_this < 2; i++) @(negedge clk);
    chk("two_beats_before_reset", 64'(beats_this >= 2), 1);
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk("rst_freeze", cam_freeze, 0);
    chk("rst_done", done_valid, 0);
    chk("rst_clear", clear_pulse, 0);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_rd_en", cam_rd_en, 0);
    exp_beats.delete();
    exp_done.delete();
    pushed = 0;
    popped = 0;
    prev_rd = 0;
    prev_stall = 0;
    d0 = done_seen;
    repeat (3) @(posedge clk);
    #2;
    rst_n = 1'b1;
    @(negedge clk);
    chk("post_rst_ready", query_ready, 1);
    chk("post_rst_freeze", cam_freeze, 0);
    repeat (10) @(negedge clk);
    chk("no_done_after_abort", 64'(done_seen), 64'(d0));
  endtask

  initial begin
    fill_cam(NE);
    repeat (2) @(posedge clk);
    #2;
    rst_n = 1'b1;
    @(negedge clk);
    chk("reset_query_ready", query_ready, 1);
    chk("reset_freeze", cam_freeze, 0);
    chk("reset_rd_en", cam_rd_en, 0);
    chk("reset_rd_idx", cam_rd_idx, 0);
    chk("reset_out_valid", out_valid, 0);
    chk("reset_out_addr", out_addr, 0);
    chk("reset_out_cnt", out_cnt, 0);
    chk("reset_out_rank", out_rank, 0);
    chk("reset_done_valid", done_valid, 0);
    chk("reset_done_num", done_num, 0);
    chk("reset_clear_pulse", clear_pulse, 0);
    for (int i = 0; i < NE; i++) cam_cnt_m[i] = i == 0 ? 90 : i == 1 ? 50 : i == 2 ? 20 : 7;
    run_query(3, 1'b0, 0);
    for (int i = 0; i < NE; i++) cam_cnt_m[i] = i == 0 ? 40 : i == 1 ? 12 : 0;
    run_query(5, 1'b0, 0);
    run_query(0, 1'b1, 0);
    fill_cam(NE);
    run_query(31, 1'b0, 0);
    fill_cam(NE);
    run_query(4, 1'b1, 1);
    reset_mid_query();
    for (int n = 0; n < 30; n++) begin
      fill_cam(int'($urandom_range(0, NE)));
      run_query(int'($urandom_range(0, 31)), 1'($urandom_range(0, 1)), int'($urandom_range(0, 2)));
    end
    repeat (5) @(negedge clk);
    chk("leftover_beats", 64'(exp_beats.size()), 0);
    chk("leftover_dones", 64'(exp_done.size()), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/topk_query_reader.md
TOPK_QUERY_READER -- requirements
Module: topk_query_reader

Interface
REQ-001 SHALL have parameter ADDR_SIZE, default 22, tracked-address width.
REQ-002 SHALL have parameter CNT_SIZE, default 32, count width.
REQ-003 SHALL have parameter NUM_ENTRY, default 25, number of sorted-CAM entries.
REQ-004 SHALL have parameter INDEX_SIZE, default 5, CAM index width (clog2(NUM_ENTRY)).
REQ-005 SHALL have parameter SETTLE_CYC, default 2, cycles waited after freeze before first read.
REQ-006 SHALL have ports: clk  in  1  single clock; rst_n  in  1  reset, asynchronous, active-low.
REQ-007 SHALL have ports: query_valid  in  1; query_ready  out  1; query_k  in  INDEX_SIZE+1 (entries requested); query_clear  in  1 (request sketch/CAM clear after readout).
REQ-008 SHALL have ports: cam_freeze  out  1 (hold CAM updates); cam_rd_en  out  1; cam_rd_idx  out  INDEX_SIZE; cam_rd_valid  in  1 (exactly 1 cycle after cam_rd_en); cam_rd_addr  in  ADDR_SIZE; cam_rd_cnt  in  CNT_SIZE.
REQ-009 SHALL have ports: out_valid  out  1; out_ready  in  1; out_addr  out  ADDR_SIZE; out_cnt  out  CNT_SIZE; out_rank  out  INDEX_SIZE.
REQ-010 SHALL have ports: done_valid  out  1 (one-cycle pulse); done_num  out  INDEX_SIZE+1 (beats emitted); clear_pulse  out  1.

Function
REQ-011 SHALL implement FSM IDLE -> SETTLE -> READ -> DRAIN -> DONE -> IDLE.
REQ-012 SHALL assert query_ready only in IDLE; query accepted on query_valid & query_ready; k and clear latched then.
REQ-013 SHALL clamp latched k to NUM_ENTRY when query_k > NUM_ENTRY.
REQ-014 SHALL go IDLE -> DONE directly when latched k == 0, emitting no beats, no reads, no cam_freeze.
REQ-015 SHALL assert cam_freeze from the cycle after acceptance through DONE inclusive, deasserted in IDLE.
REQ-016 SHALL stay in SETTLE exactly SETTLE_CYC cycles, then enter READ.
REQ-017 SHALL in READ issue cam_rd_en with cam_rd_idx = 0,1,2,... ascending, at most one per cycle.
REQ-018 SHALL issue a read only when (output-buffer occupancy + outstanding reads) < 2, giving 1 beat/cycle with out_ready held high.
REQ-019 SHALL push each cam_rd_valid return with cam_rd_cnt != 0 into a 2-entry output buffer with out_rank = its index.
REQ-020 SHALL treat a returned cam_rd_cnt == 0 as end-of-list: drop it, issue no further reads.
REQ-021 SHALL leave READ for DRAIN when k reads issued or end-of-list seen; DRAIN -> DONE when no read outstanding and buffer empty.
REQ-022 SHALL present buffer head on out_*; beat transfers on out_valid & out_ready; out_* stable while out_valid & !out_ready.
REQ-023 SHALL pulse done_valid one cycle in DONE, done_num = beats transferred (0..k).
REQ-024 SHALL pulse clear_pulse in the DONE cycle iff latched query_clear == 1.
REQ-025 SHALL count beats with a saturating-free INDEX_SIZE+1 counter (max NUM_ENTRY, no wrap possible).

Reset
REQ-026 SHALL on rst_n low asynchronously enter IDLE, empty buffer, clear outstanding/counters; query_ready=1 after release, all other outputs 0.
REQ-027 SHALL on reset mid-query abandon it: no done_valid, no clear_pulse, cam_freeze drops immediately.

Structure
REQ-028 SHALL place FSM state enum and beat struct {addr, cnt, rank} in shared package topk_pkg.
REQ-029 SHALL implement the 2-entry output buffer as sub-module topk_out_fifo (push/pop, full/empty, count).

Verification
REQ-030 k=3, CAM counts {90,50,20,7,...}, out_ready=1 -> beats (rank0,90),(rank1,50),(rank2,20) on consecutive cycles, done_num=3, exactly 3 reads.
REQ-031 k=5, CAM counts {40,12,0,...} -> beats ranks 0,1 only, no read beyond idx 3, done_num=2.
REQ-032 k=0 -> no cam_rd_en, no cam_freeze, done_valid one cycle after acceptance, done_num=0.
REQ-033 k=31 with 25 nonzero entries -> 25 beats ranks 0..24, done_num=25.
REQ-034 k=4, out_ready toggling 1/0 each cycle -> out_* stable while stalled, no beat lost or duplicated, never >2 reads buffered+outstanding.
REQ-035 k=4, query_clear=1, rst_n pulsed low after 2nd beat -> no done_valid, no clear_pulse, cam_freeze=0, query_ready=1 after release.
